// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default operand width for serial_adder.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : IDLE / SHIFT / DONE controller states
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: combinational 1-bit full adder used as the serial bit-slice.
//   a, b      : operand bits
//   c_in      : carry in
//   sum       : sum bit
//   carry_out : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ c_in;
    assign carry_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit pair per clock through a single full_adder.
//   clk, rst       : clock and synchronous active-high reset
//   start, a, b,   : request and operands, captured when not busy
//   c_in
//   busy           : high while bits are being added
//   done           : one-cycle pulse when sum/carry_out update
//   sum, carry_out : registered result of the last completed addition
//   ovf            : signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] acc_next;

    full_adder u_fa (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .c_in      (cy),
        .sum       (fa_s),
        .carry_out (fa_co)
    );

    // New sum bit enters at the top so the LSB ends up at bit 0 after WIDTH shifts.
    assign acc_next = {fa_s, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        cy    <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    acc  <= acc_next;
                    cy   <= fa_co;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= acc_next;
                        carry_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry into the MSB is the carry register during the last slice
                        ovf       <= cy ^ fa_co;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench for serial_adder (WIDTH=8); ovf checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] full;
        exp_t e;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit push);
        if (push) sb.push_back(model(x, y, ci));
        a = x;
        b = y;
        c_in = ci;
        start = 1'b1;
        step();
        acc_cyc = cyc;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        c_in = $urandom_range(0, 1);
    endtask

    task automatic wait_check(input string tag);
        logic [W-1:0] held_s;
        logic         held_c;
        exp_t e;
        held_s = sum;
        held_c = carry_out;
        while (!done && (cyc - acc_cyc) < 4 * W) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold"}, {23'd0, held_c, held_s}, {23'd0, carry_out, sum});
            step();
        end
        chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(W));
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, 32'(sum), 32'(e.s));
            chk({tag, "_carry"}, 32'(carry_out), 32'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
        end
    endtask

    task automatic check_pulse_end(input string tag);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        launch(8'h3C, 8'h0F, 1'b0, 1);
        chk("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_check("t1");
        chk("t1_sum_const", 32'(sum), 32'h4B);
        check_pulse_end("t1");

        launch(8'hFF, 8'h01, 1'b0, 1);
        wait_check("t2a");
        launch(8'hFF, 8'hFF, 1'b1, 1);
        wait_check("t2b_backtoback");
        chk("t2b_sum_const", 32'(sum), 32'hFF);
        check_pulse_end("t2b");

        launch(8'h01, 8'h01, 1'b0, 1);
        step();
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_check("t3_ignore");
        chk("t3_sum_const", 32'(sum), 32'h02);
        check_pulse_end("t3");

        launch(8'h12, 8'h34, 1'b0, 0);
        step();
        step();
        step();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        chk("t4_rst_sum", 32'(sum), 32'd0);
        chk("t4_rst_carry", 32'(carry_out), 32'd0);
        launch(8'h12, 8'h34, 1'b0, 1);
        wait_check("t4_restart");
        chk("t4_sum_const", 32'(sum), 32'h46);
        check_pulse_end("t4");

        launch(8'h7F, 8'h01, 1'b0, 1);
        wait_check("t5_7f01");
        launch(8'h80, 8'h80, 1'b0, 1);
        wait_check("t5_8080");
        launch(8'h10, 8'h20, 1'b0, 1);
        wait_check("t5_1020");
        check_pulse_end("t5");

        for (int i = 0; i < 6; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1);
            wait_check("rand");
        end
        check_pulse_end("rand");

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
